// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath strobe from the current state (plus decoded fields),
// stalls on the single-port memory handshake and counts retired instructions.
//
// state    | code | meaning
// ---------+------+-----------------------------------------------
// INIT     |  15  | reset hold, all strobes low
// FETCH    |   0  | read instruction at PC, PC+4 on ready
// DECODE   |   1  | register read, branch target precompute
// MEM_ADDR |   2  | effective address for lw/sw
// MEM_RD   |   3  | load data read, waits on mem_ready
// WB_MEM   |   4  | load writeback to rt
// MEM_WR   |   5  | store, waits on mem_ready
// EXEC_R   |   6  | R-type ALU operation
// WB_R     |   7  | R-type writeback to rd
// BRANCH   |   8  | beq compare, PC <- target if zero
// JUMP     |   9  | PC <- jump target
// EXEC_I   |  10  | addi ALU operation
// WB_I     |  11  | addi writeback to rt
module multi_cycle_ctrl #(
    parameter int MEM_WAIT_MAX = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALU_Control,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_INIT     = 4'd15;
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_WB_MEM   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_WB_R     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_EXEC_I   = 4'd10;
    localparam logic [3:0] S_WB_I     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    logic [3:0]        state;
    logic [3:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              timeout_hit;
    logic              retire;
    logic [2:0]        alu_r;
    logic              funct_ok;

    // The zero flag gates PC loading inside the datapath; the controller only issues Branch.
    logic unused_zero;
    assign unused_zero = zero;

    assign in_wait     = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout_hit = in_wait && (wait_cnt == WAIT_LIMIT);
    assign state_out   = state;

    // R-type funct decode to ALU operation
    always_comb begin
        alu_r    = 3'b000;
        funct_ok = 1'b1;
        case (funct)
            6'b100000: alu_r = 3'b010;
            6'b100010: alu_r = 3'b110;
            6'b100100: alu_r = 3'b000;
            6'b100101: alu_r = 3'b001;
            6'b101010: alu_r = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end

    // Next state and strobes; a timeout overrides the state's strobes for its cycle
    always_comb begin
        state_next  = state;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        PCSource    = 2'b00;
        ALU_Control = 3'b000;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (timeout_hit) begin
            mem_timeout = 1'b1;
            state_next  = S_FETCH;
        end else begin
            case (state)
                S_INIT: state_next = S_FETCH;
                S_FETCH: begin
                    MemRead     = 1'b1;
                    ALUSrcB     = 2'b01;
                    ALU_Control = 3'b010;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcB     = 2'b11;
                    ALU_Control = 3'b010;
                    case (opcode)
                        OP_RTYPE:      state_next = S_EXEC_R;
                        OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                        OP_BEQ:        state_next = S_BRANCH;
                        OP_J:          state_next = S_JUMP;
                        OP_ADDI:       state_next = S_EXEC_I;
                        default: begin
                            illegal_op = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    if (funct_ok) begin
                        ALU_Control = alu_r;
                        state_next  = S_WB_R;
                    end else begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_WB_R: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEM_ADDR: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b10;
                    ALU_Control = 3'b010;
                    state_next  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) state_next = S_WB_MEM;
                end
                S_WB_MEM: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) state_next = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALU_Control = 3'b110;
                    Branch      = 1'b1;
                    PCSource    = 2'b01;
                    state_next  = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    state_next = S_FETCH;
                end
                S_EXEC_I: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b10;
                    ALU_Control = 3'b010;
                    state_next  = S_WB_I;
                end
                S_WB_I: begin
                    RegWrite   = 1'b1;
                    state_next = S_FETCH;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    // An instruction retires when it leaves its final state; a store only once the write completes
    always_comb begin
        case (state)
            S_WB_R, S_WB_MEM, S_WB_I, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR: retire = mem_ready && !timeout_hit;
            default:  retire = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_INIT;
        else      state <= state_next;
    end

    // Handshake wait counter; also cleared on timeout so a stalled FETCH restarts its window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if ((state_next != state) || timeout_hit) begin
            wait_cnt <= '0;
        end else if (in_wait && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Retired-instruction counter, wraps naturally at full scale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: a per-cycle vector table for the main
// instruction mix, then hand sequences for timeout, mid-instruction reset and
// instruction-counter wrap.
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 4;

    // Control word field order:
    // IorD MemRead MemWrite IRWrite PCWrite Branch PCSource ALU_Control ALUSrcA ALUSrcB RegWrite RegDst MemtoReg illegal_op mem_timeout
    localparam logic [18:0] C_ZERO    = 19'b0_0_0_0_0_0_00_000_0_00_0_0_0_0_0;
    localparam logic [18:0] C_FWAIT   = 19'b0_1_0_0_0_0_00_010_0_01_0_0_0_0_0;
    localparam logic [18:0] C_FGO     = 19'b0_1_0_1_1_0_00_010_0_01_0_0_0_0_0;
    localparam logic [18:0] C_DEC     = 19'b0_0_0_0_0_0_00_010_0_11_0_0_0_0_0;
    localparam logic [18:0] C_DEC_BAD = 19'b0_0_0_0_0_0_00_010_0_11_0_0_0_1_0;
    localparam logic [18:0] C_JUMP    = 19'b0_0_0_0_1_0_10_000_0_00_0_0_0_0_0;
    localparam logic [18:0] C_R_SUB   = 19'b0_0_0_0_0_0_00_110_1_00_0_0_0_0_0;
    localparam logic [18:0] C_R_BAD   = 19'b0_0_0_0_0_0_00_000_1_00_0_0_0_1_0;
    localparam logic [18:0] C_WB_R    = 19'b0_0_0_0_0_0_00_000_0_00_1_1_0_0_0;
    localparam logic [18:0] C_MADDR   = 19'b0_0_0_0_0_0_00_010_1_10_0_0_0_0_0;
    localparam logic [18:0] C_MRD     = 19'b1_1_0_0_0_0_00_000_0_00_0_0_0_0_0;
    localparam logic [18:0] C_WB_MEM  = 19'b0_0_0_0_0_0_00_000_0_00_1_0_1_0_0;
    localparam logic [18:0] C_MWR     = 19'b1_0_1_0_0_0_00_000_0_00_0_0_0_0_0;
    localparam logic [18:0] C_TMO     = 19'b0_0_0_0_0_0_00_000_0_00_0_0_0_0_1;
    localparam logic [18:0] C_BR      = 19'b0_0_0_0_0_1_01_110_1_00_0_0_0_0_0;
    localparam logic [18:0] C_EXEC_I  = 19'b0_0_0_0_0_0_00_010_1_10_0_0_0_0_0;
    localparam logic [18:0] C_WB_I    = 19'b0_0_0_0_0_0_00_000_0_00_1_0_0_0_0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_SUB  = 6'b100010;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [3:0]  cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0]       PCSource;
    logic [2:0]       ALU_Control;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegWrite, RegDst, MemtoReg, illegal_op, mem_timeout;
    logic [3:0]       state_out;
    logic [CNT_W-1:0] instr_count;
    logic [18:0]      ctl_act;

    int passed = 0;
    int total  = 0;
    vec_t tbl[$];

    multi_cycle_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .PCSource(PCSource),
        .ALU_Control(ALU_Control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state_out(state_out), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctl_act = {IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, PCSource,
                      ALU_Control, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg,
                      illegal_op, mem_timeout};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [18:0] ctl,
                       input logic [3:0] cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        opcode = op; funct = fn; mem_ready = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // j
        add(OP_J,    6'd0,   0, 1, 4'd15, C_ZERO,    4'd0);
        add(OP_J,    6'd0,   0, 1, 4'd0,  C_FGO,     4'd0);
        add(OP_J,    6'd0,   0, 1, 4'd1,  C_DEC,     4'd0);
        add(OP_J,    6'd0,   0, 1, 4'd9,  C_JUMP,    4'd0);
        // R-type sub
        add(OP_R,    FN_SUB, 0, 1, 4'd0,  C_FGO,     4'd1);
        add(OP_R,    FN_SUB, 0, 1, 4'd1,  C_DEC,     4'd1);
        add(OP_R,    FN_SUB, 0, 1, 4'd6,  C_R_SUB,   4'd1);
        add(OP_R,    FN_SUB, 0, 1, 4'd7,  C_WB_R,    4'd1);
        // lw with three wait cycles
        add(OP_LW,   6'd0,   0, 1, 4'd0,  C_FGO,     4'd2);
        add(OP_LW,   6'd0,   0, 1, 4'd1,  C_DEC,     4'd2);
        add(OP_LW,   6'd0,   0, 1, 4'd2,  C_MADDR,   4'd2);
        add(OP_LW,   6'd0,   0, 0, 4'd3,  C_MRD,     4'd2);
        add(OP_LW,   6'd0,   0, 0, 4'd3,  C_MRD,     4'd2);
        add(OP_LW,   6'd0,   0, 0, 4'd3,  C_MRD,     4'd2);
        add(OP_LW,   6'd0,   0, 1, 4'd3,  C_MRD,     4'd2);
        add(OP_LW,   6'd0,   0, 1, 4'd4,  C_WB_MEM,  4'd2);
        // beq, zero=1
        add(OP_BEQ,  6'd0,   1, 1, 4'd0,  C_FGO,     4'd3);
        add(OP_BEQ,  6'd0,   1, 1, 4'd1,  C_DEC,     4'd3);
        add(OP_BEQ,  6'd0,   1, 1, 4'd8,  C_BR,      4'd3);
        // illegal opcode
        add(OP_BAD,  6'd0,   0, 1, 4'd0,  C_FGO,     4'd4);
        add(OP_BAD,  6'd0,   0, 1, 4'd1,  C_DEC_BAD, 4'd4);
        // R-type illegal funct
        add(OP_R,    6'd0,   0, 1, 4'd0,  C_FGO,     4'd4);
        add(OP_R,    6'd0,   0, 1, 4'd1,  C_DEC,     4'd4);
        add(OP_R,    6'd0,   0, 1, 4'd6,  C_R_BAD,   4'd4);
        // addi
        add(OP_ADDI, 6'd0,   0, 1, 4'd0,  C_FGO,     4'd4);
        add(OP_ADDI, 6'd0,   0, 1, 4'd1,  C_DEC,     4'd4);
        add(OP_ADDI, 6'd0,   0, 1, 4'd10, C_EXEC_I,  4'd4);
        add(OP_ADDI, 6'd0,   0, 1, 4'd11, C_WB_I,    4'd4);
        // sw, immediate ready
        add(OP_SW,   6'd0,   0, 1, 4'd0,  C_FGO,     4'd5);
        add(OP_SW,   6'd0,   0, 1, 4'd1,  C_DEC,     4'd5);
        add(OP_SW,   6'd0,   0, 1, 4'd2,  C_MADDR,   4'd5);
        add(OP_SW,   6'd0,   0, 1, 4'd5,  C_MWR,     4'd5);
        // j with one fetch stall
        add(OP_J,    6'd0,   0, 0, 4'd0,  C_FWAIT,   4'd6);
        add(OP_J,    6'd0,   0, 1, 4'd0,  C_FGO,     4'd6);
        add(OP_J,    6'd0,   0, 1, 4'd1,  C_DEC,     4'd6);
        add(OP_J,    6'd0,   0, 1, 4'd9,  C_JUMP,    4'd6);

        // reset held
        drive(OP_J, 6'd0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(state_out), 32'd15);
        chk("reset_ctl", 32'(ctl_act), 32'(C_ZERO));
        chk("reset_cnt", 32'(instr_count), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[i]) begin
            opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_state", i), 32'(state_out), 32'(tbl[i].st));
            chk($sformatf("row%0d_ctl", i), 32'(ctl_act), 32'(tbl[i].ctl));
            chk($sformatf("row%0d_cnt", i), 32'(instr_count), 32'(tbl[i].cnt));
            @(negedge clk);
        end
        zero = 1'b0;

        // sw timeout: four stalled MEM_WR cycles, then mem_timeout with no strobes
        chk("pre_tmo_cnt", 32'(instr_count), 32'd7);
        repeat (3) begin
            drive(OP_SW, 6'd0, 1'b1);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            drive(OP_SW, 6'd0, 1'b0);
            chk($sformatf("tmo_wait%0d_state", k), 32'(state_out), 32'd5);
            chk($sformatf("tmo_wait%0d_ctl", k), 32'(ctl_act), 32'(C_MWR));
            @(negedge clk);
        end
        drive(OP_SW, 6'd0, 1'b0);
        chk("tmo_pulse_state", 32'(state_out), 32'd5);
        chk("tmo_pulse_ctl", 32'(ctl_act), 32'(C_TMO));
        @(negedge clk);
        drive(OP_SW, 6'd0, 1'b0);
        chk("tmo_after_state", 32'(state_out), 32'd0);
        chk("tmo_after_ctl", 32'(ctl_act), 32'(C_FWAIT));
        chk("tmo_after_cnt", 32'(instr_count), 32'd7);

        // reset asserted while in MEM_WR
        repeat (3) begin
            drive(OP_SW, 6'd0, 1'b1);
            @(negedge clk);
        end
        drive(OP_SW, 6'd0, 1'b0);
        chk("mwr_before_rst", 32'(state_out), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("midrst_state", 32'(state_out), 32'd15);
        chk("midrst_ctl", 32'(ctl_act), 32'(C_ZERO));
        chk("midrst_cnt", 32'(instr_count), 32'd0);

        // counter wrap: 16 jumps on a 4-bit counter
        @(negedge clk);
        rst = 1'b1;
        drive(OP_J, 6'd0, 1'b1);
        chk("wrap_init", 32'(state_out), 32'd15);
        for (int n = 1; n <= 16; n++) begin
            repeat (3) begin
                @(negedge clk);
                drive(OP_J, 6'd0, 1'b1);
            end
            chk($sformatf("wrap_j%0d_state", n), 32'(state_out), 32'd9);
            chk($sformatf("wrap_j%0d_cnt", n), 32'(instr_count), 32'((n - 1) % 16));
        end
        @(negedge clk);
        drive(OP_J, 6'd0, 1'b1);
        chk("wrap_zero", 32'(instr_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
